muldiv_arbiter: RTL and testbench

MULDIV_ARBITER -- requirements
Module: muldiv_arbiter

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/rr_arbiter.sv | 19 +
 rtl/muldiv_arbiter.sv | 123 ++++++++++++
 tb/tb_muldiv_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the muldiv arbiter: FSM states, MULDIV op codes and the latched request.
// Width macros normally come from the project defines; these guarded defaults cover standalone builds.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef HART_ID_W
`define HART_ID_W 2
`endif
`ifndef REG_ADDR_W
`define REG_ADDR_W 5
`endif

package muldiv_pkg;
  localparam int XLEN       = `XLEN;
  localparam int HART_ID_W  = `HART_ID_W;
  localparam int REG_ADDR_W = `REG_ADDR_W;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} arb_state_e;

  typedef struct packed {
    logic [2:0]            op;
    logic [XLEN-1:0]       a;
    logic [XLEN-1:0]       b;
    logic [REG_ADDR_W-1:0] rd;
    logic [HART_ID_W-1:0]  hart;
  } muldiv_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: grants the first requester at or above ptr, wrapping to the lowest.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);
  logic [N-1:0] ge_ptr, hi, pick;

  always_comb begin
    ge_ptr = ~((N'(1) << ptr) - N'(1));
    hi     = req & ge_ptr;
    pick   = (|hi) ? hi : req;
    // isolate lowest set bit
    grant  = pick & (~pick + N'(1));
  end
endmodule

// File: rtl/muldiv_arbiter.sv
// Shares one multi-cycle mul/div unit among NUM_HARTS requesters, one op in flight at a time.
module muldiv_arbiter
  import muldiv_pkg::*;
#(
  parameter int NUM_HARTS = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_HARTS-1:0]                  req_valid,
  input  logic [NUM_HARTS-1:0][2:0]             req_op,
  input  logic [NUM_HARTS-1:0][XLEN-1:0]        req_a,
  input  logic [NUM_HARTS-1:0][XLEN-1:0]        req_b,
  input  logic [NUM_HARTS-1:0][REG_ADDR_W-1:0]  req_rd,
  output logic [NUM_HARTS-1:0]                  req_ready,
  input  logic [NUM_HARTS-1:0]                  hart_flush,
  output logic [NUM_HARTS-1:0]                  rsp_valid,
  output logic [XLEN-1:0]                       rsp_result,
  output logic [REG_ADDR_W-1:0]                 rsp_rd,
  output logic                                  muldiv_start,
  output logic [2:0]                            muldiv_op,
  output logic [XLEN-1:0]                       muldiv_a,
  output logic [XLEN-1:0]                       muldiv_b,
  output logic [HART_ID_W-1:0]                  muldiv_hart_id,
  output logic [REG_ADDR_W-1:0]                 muldiv_rd,
  input  logic                                  muldiv_busy,
  input  logic                                  muldiv_done,
  input  logic [XLEN-1:0]                       muldiv_result,
  input  logic [HART_ID_W-1:0]                  muldiv_done_hart_id,
  input  logic [REG_ADDR_W-1:0]                 muldiv_done_rd,
  output logic                                  arb_busy,
  output logic                                  err_sticky
);
  arb_state_e             state_q, state_d;
  logic [HART_ID_W-1:0]   rr_ptr;
  muldiv_req_t            cur, nxt;
  logic                   discard;
  logic [NUM_HARTS-1:0]   arb_req, grant, hart_oh;
  logic [HART_ID_W-1:0]   win_id;
  logic                   done_ok, err_set, flush_cur;

  // rsp_rd always comes from the latched request, the unit's echo is not needed
  logic unused_done_rd;
  assign unused_done_rd = ^muldiv_done_rd;

  assign arb_req = (rst_n && state_q == S_IDLE && !muldiv_busy) ? (req_valid & ~hart_flush) : '0;

  rr_arbiter #(.N(NUM_HARTS), .PTR_W(HART_ID_W)) u_rr (
    .req   (arb_req),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  always_comb begin
    win_id = '0;
    for (int i = 0; i < NUM_HARTS; i++)
      if (grant[i]) win_id = HART_ID_W'(i);
  end

  always_comb begin
    nxt      = '0;
    nxt.op   = req_op[win_id];
    nxt.a    = req_a[win_id];
    nxt.b    = req_b[win_id];
    nxt.rd   = req_rd[win_id];
    nxt.hart = win_id;
  end

  assign req_ready      = grant;
  assign arb_busy       = (state_q != S_IDLE);
  assign muldiv_start   = (state_q == S_ISSUE);
  assign muldiv_op      = cur.op;
  assign muldiv_a       = cur.a;
  assign muldiv_b       = cur.b;
  assign muldiv_hart_id = cur.hart;
  assign muldiv_rd      = cur.rd;

  assign hart_oh   = NUM_HARTS'(1) << cur.hart;
  assign flush_cur = hart_flush[cur.hart];
  assign done_ok   = (state_q == S_WAIT) && muldiv_done && (muldiv_done_hart_id == cur.hart);
  // a done the FSM is not waiting for, or tagged for another hart, is a protocol error
  assign err_set   = muldiv_done && ((state_q != S_WAIT) || (muldiv_done_hart_id != cur.hart));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|grant) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (done_ok) state_d = S_DRAIN;
      S_DRAIN: if (!muldiv_busy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_ptr     <= '0;
      cur        <= '0;
      discard    <= 1'b0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_rd     <= '0;
      err_sticky <= 1'b0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= '0;
      if (|grant) begin
        cur     <= nxt;
        rr_ptr  <= (win_id == HART_ID_W'(NUM_HARTS - 1)) ? '0 : win_id + 1'b1;
        discard <= 1'b0;
      end else if ((state_q == S_ISSUE || state_q == S_WAIT) && flush_cur) begin
        discard <= 1'b1;
      end
      if (done_ok) begin
        rsp_result <= muldiv_result;
        rsp_rd     <= cur.rd;
        // a flush landing in the done cycle itself still suppresses the pulse
        if (!(discard || flush_cur)) rsp_valid <= hart_oh;
      end
      if (err_set) err_sticky <= 1'b1;
    end
  end
endmodule

// File: tb/tb_muldiv_arbiter.sv
// Directed bench for muldiv_arbiter with a behavioural mul/div unit and event logs.
module tb_muldiv_arbiter;
  import muldiv_pkg::*;
  localparam int NH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NH-1:0]                 req_valid, req_ready, hart_flush, rsp_valid;
  logic [NH-1:0][2:0]            req_op;
  logic [NH-1:0][XLEN-1:0]       req_a, req_b;
  logic [NH-1:0][REG_ADDR_W-1:0] req_rd;
  logic [XLEN-1:0]               rsp_result, muldiv_a, muldiv_b, muldiv_result;
  logic [REG_ADDR_W-1:0]         rsp_rd, muldiv_rd, muldiv_done_rd;
  logic                          muldiv_start, muldiv_busy, muldiv_done, arb_busy, err_sticky;
  logic [2:0]                    muldiv_op;
  logic [HART_ID_W-1:0]          muldiv_hart_id, muldiv_done_hart_id;

  muldiv_arbiter #(.NUM_HARTS(NH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .req_ready(req_ready), .hart_flush(hart_flush),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_rd(rsp_rd),
    .muldiv_start(muldiv_start), .muldiv_op(muldiv_op), .muldiv_a(muldiv_a), .muldiv_b(muldiv_b),
    .muldiv_hart_id(muldiv_hart_id), .muldiv_rd(muldiv_rd),
    .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done), .muldiv_result(muldiv_result),
    .muldiv_done_hart_id(muldiv_done_hart_id), .muldiv_done_rd(muldiv_done_rd),
    .arb_busy(arb_busy), .err_sticky(err_sticky)
  );

  int nchk = 0, nfail = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // unit model: done asserted L cycles after the start cycle
  function automatic int lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 4;
    if (b == 32'd0) return 1;
    if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] pu, ps, psu;
    logic ovf;
    pu  = {32'd0, a} * {32'd0, b};
    ps  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    psu = {{32{a[31]}}, a} * {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_MUL:    return pu[31:0];
      OP_MULH:   return ps[63:32];
      OP_MULHSU: return psu[63:32];
      OP_MULHU:  return pu[63:32];
      OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : $signed(a) / $signed(b);
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:    return (b == 0) ? a : ovf ? 32'd0 : $signed(a) % $signed(b);
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  logic        u_busy, tb_done;
  int          u_cnt;
  logic [31:0] u_res;
  logic [1:0]  u_hart, tb_done_hart;
  logic [4:0]  u_rd;

  assign muldiv_busy         = u_busy;
  assign muldiv_done         = (u_busy && u_cnt == 1) || tb_done;
  assign muldiv_result       = u_res;
  assign muldiv_done_hart_id = tb_done ? tb_done_hart : u_hart;
  assign muldiv_done_rd      = u_rd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_busy <= 1'b0; u_cnt <= 0; u_res <= '0; u_hart <= '0; u_rd <= '0;
    end else if (muldiv_start) begin
      u_busy <= 1'b1;
      u_cnt  <= lat(muldiv_op, muldiv_a, muldiv_b);
      u_res  <= calc(muldiv_op, muldiv_a, muldiv_b);
      u_hart <= muldiv_hart_id;
      u_rd   <= muldiv_rd;
    end else if (u_busy) begin
      u_cnt <= u_cnt - 1;
      if (u_cnt == 1) u_busy <= 1'b0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          g_cyc[$], g_hart[$], s_cyc[$], r_cyc[$], r_vec[$];
  logic [31:0] r_res[$];
  logic [4:0]  r_rd[$];

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_onehot", 64'($countones(req_ready) <= 1), 1);
      chk("ready_busy", req_ready & {NH{arb_busy}}, 0);
      for (int i = 0; i < NH; i++)
        if (req_ready[i]) begin g_cyc.push_back(cyc); g_hart.push_back(i); end
      if (muldiv_start) s_cyc.push_back(cyc);
      if (|rsp_valid) begin
        r_cyc.push_back(cyc); r_vec.push_back(int'(rsp_valid));
        r_res.push_back(rsp_result); r_rd.push_back(rsp_rd);
      end
    end
  end

  task automatic clr();
    g_cyc.delete(); g_hart.delete(); s_cyc.delete();
    r_cyc.delete(); r_vec.delete(); r_res.delete(); r_rd.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int h, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
    req_op[h] = op; req_a[h] = a; req_b[h] = b; req_rd[h] = rd; req_valid[h] = 1'b1;
  endtask

  task automatic wait_grants(input int n, input int max, input string tag);
    int k = 0;
    while (g_cyc.size() < n && k < max) begin tick(1); k++; end
    chk(tag, g_cyc.size(), n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; hart_flush = '0; tb_done = 1'b0;
    tick(2);
    rst_n = 1'b1;
    clr();
  endtask

  int t0, rc;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; req_rd = '0;
    hart_flush = '0; tb_done = 1'b0; tb_done_hart = '0;
    tick(3);
    req_valid = '1; #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_rd", rsp_rd, 0);
    chk("rst_start", muldiv_start, 0);
    chk("rst_unit_req", {muldiv_op, muldiv_a, muldiv_b, muldiv_hart_id, muldiv_rd}, 0);
    chk("rst_busy", arb_busy, 0);
    chk("rst_err", err_sticky, 0);
    req_valid = '0;
    tick(1);
    rst_n = 1'b1;
    clr();

    // single MUL; operand change after grant must not leak in
    set_req(0, OP_MUL, 7, 6, 5);
    wait_grants(1, 5, "t1_grants");
    req_valid = '0; req_a[0] = 99;
    tick(10);
    if (g_cyc.size() == 1) begin
      t0 = g_cyc[0];
      chk("t1_hart", g_hart[0], 0);
      chk("t1_starts", s_cyc.size(), 1);
      if (s_cyc.size() == 1) chk("t1_start_cyc", s_cyc[0], t0 + 1);
      chk("t1_rsps", r_cyc.size(), 1);
      if (r_cyc.size() == 1) begin
        chk("t1_rsp_cyc", r_cyc[0], t0 + 6);
        chk("t1_rsp_vec", r_vec[0], 1);
        chk("t1_rsp_res", r_res[0], 42);
        chk("t1_rsp_rd", r_rd[0], 5);
      end
    end

    // all harts DIVU 100/7 back to back
    do_reset();
    for (int h = 0; h < NH; h++) set_req(h, OP_DIVU, 100, 7, 5'(h + 1));
    wait_grants(5, 250, "t2_grants");
    req_valid = '0;
    tick(45);
    if (g_cyc.size() == 5) begin
      for (int k = 0; k < 5; k++) chk($sformatf("t2_order%0d", k), g_hart[k], k % NH);
      chk("t2_starts", s_cyc.size(), 5);
      chk("t2_rsps", r_cyc.size(), 5);
      for (int k = 0; k < 5 && k < s_cyc.size(); k++)
        chk($sformatf("t2_start%0d", k), s_cyc[k], g_cyc[k] + 1);
      for (int k = 1; k < 5; k++) chk($sformatf("t2_gap%0d", k), g_cyc[k] - g_cyc[k-1], 36);
      for (int k = 0; k < 5 && k < r_cyc.size(); k++) begin
        chk($sformatf("t2_res%0d", k), r_res[k], 14);
        chk($sformatf("t2_vec%0d", k), r_vec[k], 1 << (k % NH));
        chk($sformatf("t2_lat%0d", k), r_cyc[k], g_cyc[k] + 35);
      end
    end

    // divide by zero, then signed-overflow REM: short path
    do_reset();
    set_req(2, OP_DIV, 5, 0, 7);
    wait_grants(1, 5, "t3a_grants");
    req_valid = '0;
    tick(6);
    chk("t3a_rsps", r_cyc.size(), 1);
    if (r_cyc.size() == 1 && g_cyc.size() == 1) begin
      chk("t3a_lat", r_cyc[0], g_cyc[0] + 3);
      chk("t3a_vec", r_vec[0], 4);
      chk("t3a_res", r_res[0], 32'hFFFF_FFFF);
    end
    clr();
    set_req(2, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 8);
    wait_grants(1, 5, "t3b_grants");
    req_valid = '0;
    tick(6);
    chk("t3b_rsps", r_cyc.size(), 1);
    if (r_cyc.size() == 1 && g_cyc.size() == 1) begin
      chk("t3b_lat", r_cyc[0], g_cyc[0] + 3);
      chk("t3b_res", r_res[0], 0);
    end

    // flush of in-flight hart 1 DIV while hart 3 waits
    do_reset();
    set_req(1, OP_DIV, 100, 7, 2);
    wait_grants(1, 5, "t4_grant1");
    t0 = (g_cyc.size() > 0) ? g_cyc[0] : cyc - 1;
    req_valid = '0;
    set_req(3, OP_DIVU, 100, 7, 9);
    while (cyc < t0 + 10) tick(1);
    hart_flush[1] = 1'b1;
    tick(1);
    hart_flush = '0;
    wait_grants(2, 60, "t4_grant2");
    req_valid = '0;
    tick(40);
    if (g_cyc.size() == 2) begin
      chk("t4_hart2", g_hart[1], 3);
      chk("t4_grant2_cyc", g_cyc[1], t0 + 36);
      chk("t4_rsps", r_cyc.size(), 1);
      if (r_cyc.size() == 1) begin
        chk("t4_vec", r_vec[0], 8);
        chk("t4_res", r_res[0], 14);
        chk("t4_lat", r_cyc[0], g_cyc[1] + 35);
      end
    end
    chk("t4_no_err", err_sticky, 0);

    // reset in the middle of a DIV, then MULHU right at release
    do_reset();
    set_req(0, OP_DIV, 100, 7, 4);
    wait_grants(1, 5, "t5_grant_old");
    t0 = (g_cyc.size() > 0) ? g_cyc[0] : cyc - 1;
    req_valid = '0;
    while (cyc < t0 + 5) tick(1);
    rst_n = 1'b0; #1;
    chk("t5_busy", arb_busy, 0);
    chk("t5_start", muldiv_start, 0);
    chk("t5_unit_req", {muldiv_op, muldiv_a, muldiv_b, muldiv_hart_id, muldiv_rd}, 0);
    chk("t5_rsp", {rsp_valid, rsp_result, rsp_rd}, 0);
    tick(2);
    clr();
    set_req(0, OP_MULHU, 32'hFFFF_FFFF, 2, 3);
    rst_n = 1'b1;
    rc = cyc;
    wait_grants(1, 3, "t5_grant_new");
    req_valid = '0;
    tick(45);
    if (g_cyc.size() == 1) chk("t5_grant_cyc", g_cyc[0], rc);
    chk("t5_rsps", r_cyc.size(), 1);
    if (r_cyc.size() == 1) begin
      chk("t5_lat", r_cyc[0], rc + 6);
      chk("t5_vec", r_vec[0], 1);
      chk("t5_res", r_res[0], 1);
    end
    chk("t5_no_err", err_sticky, 0);

    // stray done while idle
    clr();
    tb_done = 1'b1; tb_done_hart = 2'd0;
    tick(1);
    tb_done = 1'b0;
    chk("t6_err", err_sticky, 1);
    chk("t6_busy", arb_busy, 0);
    tick(2);
    chk("t6_err_sticky", err_sticky, 1);
    chk("t6_rsps", r_cyc.size(), 0);
    chk("t6_grants", g_cyc.size(), 0);

    // flush in the request cycle excludes that hart
    do_reset();
    set_req(0, OP_MUL, 1, 1, 1);
    set_req(1, OP_MUL, 2, 3, 2);
    hart_flush[0] = 1'b1; #1;
    chk("t7_flush_excl", req_ready, 4'b0010);
    tick(1);
    req_valid = '0; hart_flush = '0;
    tick(10);
    chk("t7_rsps", r_cyc.size(), 1);
    if (r_cyc.size() == 1) begin
      chk("t7_vec", r_vec[0], 2);
      chk("t7_res", r_res[0], 6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
